// File: rtl/imu_spi_pkg.sv
// Shared types and constants for the IMU SPI sequencer: FSM states, the
// power-up configuration table and the pitch-rate read commands.
package imu_spi_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0,
        CFG_WAIT = 3'd1,
        IDLE     = 3'd2,
        RD_LO    = 3'd3,
        LO_WAIT  = 3'd4,
        HI_WAIT  = 3'd5
    } state_t;

    localparam int          CFG_LEN = 4;
    localparam logic [15:0] CFG [0:CFG_LEN-1] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    localparam logic [15:0] RD_PTCH_L = {8'hA2, 8'h00};
    localparam logic [15:0] RD_PTCH_H = {8'hA3, 8'h00};

    // Out-of-range indices return a harmless all-zero frame.
    function automatic logic [15:0] cfg_word(input logic [7:0] idx);
        logic [15:0] word;
        if (idx < 8'(CFG_LEN)) begin
            word = CFG[idx[1:0]];
        end else begin
            word = 16'h0000;
        end
        return word;
    endfunction

endpackage

// File: rtl/imu_spi_seq_int_sync.sv
// Brings the asynchronous data-ready interrupt into the clk domain and
// produces a single-cycle pulse on each synchronized rising edge.
module int_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic int_async,
    output logic int_rise
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Two synchronizer stages followed by one history stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= int_async;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign int_rise = sync_r & ~prev_r;

endmodule

// File: rtl/imu_spi_seq.sv
// IMU SPI sequencer: power-up wait, configuration writes, then a low/high
// pitch-rate read pair for every data-ready interrupt.
module imu_spi_seq
    import imu_spi_pkg::*;
#(
    parameter int INIT_WAIT_W = 16,
    parameter int N_CFG       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    output logic [15:0] ptch_rt,
    output logic        vld,
    output logic        cfg_done
);

    localparam int IDX_W = $clog2(N_CFG) + 1;

    state_t                   state_r, state_n;
    logic [INIT_WAIT_W-1:0]   timer_r, timer_n;
    logic [IDX_W-1:0]         cfg_idx_r, cfg_idx_n;
    logic [7:0]               lo_byte_r, lo_byte_n;
    logic                     int_pend_r, int_pend_n;
    logic                     spi_wrt_n, vld_n, cfg_done_n;
    logic [15:0]              spi_cmd_n, ptch_rt_n;
    logic                     int_rise_s, clr_pend_s, done_s;
    logic                     unused_rd_hi_s;

    assign unused_rd_hi_s = ^spi_rd_data[15:8];

    int_sync_edge u_int_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .int_async (INT),
        .int_rise  (int_rise_s)
    );

    // While spi_wrt is high the engine has not yet cleared done, so it is stale
    assign done_s = spi_done & ~spi_wrt;

    // Next-state and next-output decode
    always_comb begin
        state_n    = state_r;
        timer_n    = timer_r;
        cfg_idx_n  = cfg_idx_r;
        lo_byte_n  = lo_byte_r;
        spi_wrt_n  = 1'b0;
        spi_cmd_n  = spi_cmd;
        ptch_rt_n  = ptch_rt;
        vld_n      = 1'b0;
        cfg_done_n = cfg_done;
        clr_pend_s = 1'b0;
        case (state_r)
            PWR_WAIT: begin
                if (timer_r == {INIT_WAIT_W{1'b1}}) begin
                    spi_cmd_n = cfg_word(8'd0);
                    spi_wrt_n = 1'b1;
                    state_n   = CFG_WAIT;
                end else begin
                    timer_n = timer_r + INIT_WAIT_W'(1);
                end
            end
            CFG_WAIT: begin
                if (done_s) begin
                    cfg_idx_n = cfg_idx_r + IDX_W'(1);
                    if (cfg_idx_r == IDX_W'(N_CFG - 1)) begin
                        cfg_done_n = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        spi_cmd_n = cfg_word(8'(cfg_idx_r) + 8'd1);
                        spi_wrt_n = 1'b1;
                    end
                end else begin
                    state_n = CFG_WAIT;
                end
            end
            IDLE: begin
                if (int_pend_r) begin
                    state_n = RD_LO;
                end else begin
                    state_n = IDLE;
                end
            end
            RD_LO: begin
                spi_cmd_n  = RD_PTCH_L;
                spi_wrt_n  = 1'b1;
                clr_pend_s = 1'b1;
                state_n    = LO_WAIT;
            end
            LO_WAIT: begin
                if (done_s) begin
                    lo_byte_n = spi_rd_data[7:0];
                    spi_cmd_n = RD_PTCH_H;
                    spi_wrt_n = 1'b1;
                    state_n   = HI_WAIT;
                end else begin
                    state_n = LO_WAIT;
                end
            end
            HI_WAIT: begin
                if (done_s) begin
                    ptch_rt_n = {spi_rd_data[7:0], lo_byte_r};
                    vld_n     = 1'b1;
                    state_n   = IDLE;
                end else begin
                    state_n = HI_WAIT;
                end
            end
            default: begin
                state_n = PWR_WAIT;
            end
        endcase
    end

    // Pending request: a new rise beats the RD_LO clear; ignored until configured
    always_comb begin
        int_pend_n = int_pend_r;
        if (!cfg_done) begin
            int_pend_n = 1'b0;
        end else if (int_rise_s) begin
            int_pend_n = 1'b1;
        end else if (clr_pend_s) begin
            int_pend_n = 1'b0;
        end else begin
            int_pend_n = int_pend_r;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= PWR_WAIT;
            timer_r    <= '0;
            cfg_idx_r  <= '0;
            lo_byte_r  <= 8'h00;
            int_pend_r <= 1'b0;
            spi_wrt    <= 1'b0;
            spi_cmd    <= 16'h0000;
            ptch_rt    <= 16'h0000;
            vld        <= 1'b0;
            cfg_done   <= 1'b0;
        end else begin
            state_r    <= state_n;
            timer_r    <= timer_n;
            cfg_idx_r  <= cfg_idx_n;
            lo_byte_r  <= lo_byte_n;
            int_pend_r <= int_pend_n;
            spi_wrt    <= spi_wrt_n;
            spi_cmd    <= spi_cmd_n;
            ptch_rt    <= ptch_rt_n;
            vld        <= vld_n;
            cfg_done   <= cfg_done_n;
        end
    end

endmodule

// File: tb/tb_imu_spi_seq.sv
// Self-checking bench for imu_spi_seq: SPI responder with 40-clock frames,
// frame/pitch-rate scoreboard checked every cycle, plus directed scenarios.
module tb_imu_spi_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        INT;
    logic        spi_done;
    logic [15:0] spi_rd_data;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic [15:0] ptch_rt;
    logic        vld;
    logic        cfg_done;

    int checks   = 0;
    int failures = 0;

    logic [15:0] rd_q[$];
    logic [15:0] exp_frames[$];
    logic [15:0] exp_ptch[$];

    int          busy_cnt;
    logic [15:0] rsp_cmd;

    imu_spi_seq #(.INIT_WAIT_W(4), .N_CFG(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .INT         (INT),
        .spi_done    (spi_done),
        .spi_rd_data (spi_rd_data),
        .spi_wrt     (spi_wrt),
        .spi_cmd     (spi_cmd),
        .ptch_rt     (ptch_rt),
        .vld         (vld),
        .cfg_done    (cfg_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // SPI engine stand-in: done is a level, cleared on accepting wrt, set 40 clocks later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_done    <= 1'b0;
            spi_rd_data <= 16'h0000;
            busy_cnt    <= 0;
            rsp_cmd     <= 16'h0000;
        end else if (spi_wrt) begin
            spi_done <= 1'b0;
            busy_cnt <= 40;
            rsp_cmd  <= spi_cmd;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                spi_done <= 1'b1;
                if ((rsp_cmd[15:8] == 8'hA2 || rsp_cmd[15:8] == 8'hA3) && rd_q.size() > 0)
                    spi_rd_data <= rd_q.pop_front();
                else
                    spi_rd_data <= 16'h0000;
            end
        end
    end

    // Scoreboard model state
    int          samp;
    int          cfg_rises;
    logic        seen4, prev_wrt, prev_done, outstanding, first_wrt_seen;
    logic [15:0] cur_cmd, last_ptch, e;

    always @(negedge clk) begin
        if (!rst_n) begin
            samp = 0; cfg_rises = 0; seen4 = 0; prev_wrt = 0; prev_done = 0;
            outstanding = 0; first_wrt_seen = 0; last_ptch = 16'h0000;
            exp_frames.delete();
            exp_ptch.delete();
            exp_frames.push_back(16'h0D02);
            exp_frames.push_back(16'h1053);
            exp_frames.push_back(16'h1150);
            exp_frames.push_back(16'h1460);
        end else begin
            samp++;
            chk("cfg_done_level", {31'd0, cfg_done}, {31'd0, seen4});
            if (spi_wrt) begin
                if (prev_wrt) chk("wrt_back_to_back", 32'd1, 32'd0);
                if (!first_wrt_seen) begin
                    chk("pwr_wait_len", samp, 16);
                    first_wrt_seen = 1'b1;
                end
                if (exp_frames.size() == 0) begin
                    chk("unexpected_frame", {16'd0, spi_cmd}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_frames.pop_front();
                    chk("frame_cmd", {16'd0, spi_cmd}, {16'd0, e});
                end
                cur_cmd = spi_cmd;
                outstanding = 1'b1;
            end else if (outstanding) begin
                chk("cmd_hold", {16'd0, spi_cmd}, {16'd0, cur_cmd});
            end
            if (spi_done && !prev_done) begin
                outstanding = 1'b0;
                if (cfg_rises < 4) cfg_rises++;
            end
            if (vld) begin
                chk("vld_after_cfg", {31'd0, cfg_done}, 32'd1);
                if (exp_ptch.size() == 0) begin
                    chk("unexpected_vld", {16'd0, ptch_rt}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_ptch.pop_front();
                    chk("ptch_rt", {16'd0, ptch_rt}, {16'd0, e});
                    last_ptch = e;
                end
            end else begin
                chk("ptch_hold", {16'd0, ptch_rt}, {16'd0, last_ptch});
            end
            seen4 = (cfg_rises == 4);
            prev_wrt = spi_wrt;
            prev_done = spi_done;
        end
    end

    task automatic wait_wrt(input string name, output int n);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (spi_wrt) begin
                n = i;
                break;
            end
        end
        if (n == 0) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_vld(input string name);
        int n;
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (vld) begin
                n = i;
                break;
            end
        end
        if (n == 0) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_cfg(input string name);
        int n;
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (cfg_done) begin
                n = i;
                break;
            end
        end
        if (n == 0) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Queue one read pair: responder data plus the frames and word it must yield
    task automatic expect_read(input logic [15:0] lo, input logic [15:0] hi);
        rd_q.push_back(lo);
        rd_q.push_back(hi);
        exp_frames.push_back(16'hA200);
        exp_frames.push_back(16'hA300);
        exp_ptch.push_back({hi[7:0], lo[7:0]});
    endtask

    int n;

    initial begin
        rst_n = 1'b0;
        INT   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_spi_wrt", {31'd0, spi_wrt}, 32'd0);
        chk("rst_spi_cmd", {16'd0, spi_cmd}, 32'd0);
        chk("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;

        // Interrupts during power-up wait and configuration must be dropped
        repeat (3) @(posedge clk);
        INT = 1'b1;
        repeat (4) @(posedge clk);
        INT = 1'b0;
        repeat (40) @(posedge clk);
        INT = 1'b1;
        repeat (10) @(posedge clk);
        INT = 1'b0;
        repeat (40) @(posedge clk);
        INT = 1'b1;
        wait_cfg("cfg_done_1");
        repeat (100) @(posedge clk);
        INT = 1'b0;
        repeat (20) @(posedge clk);
        chk("no_read_before_new_int", exp_frames.size(), 0);

        // Single read and interrupt latency from IDLE
        expect_read(16'h00CD, 16'h00AB);
        @(negedge clk);
        INT = 1'b1;
        wait_wrt("int_latency", n);
        chk("int_to_wrt_latency", n, 5);
        wait_vld("read1");
        chk("ptch_abcd", {16'd0, ptch_rt}, 32'h0000_ABCD);
        @(posedge clk); #1;
        chk("vld_one_cycle", {31'd0, vld}, 32'd0);
        @(negedge clk);
        INT = 1'b0;
        repeat (20) @(posedge clk);

        // Interrupt during LO_WAIT is serviced right after; multiple rises collapse
        expect_read(16'h0080, 16'h00FF);
        expect_read(16'hC311, 16'h5A22);
        expect_read(16'h0033, 16'h0044);
        @(negedge clk);
        INT = 1'b1;
        wait_wrt("read2_lo", n);
        repeat (3) @(posedge clk);
        INT = 1'b0;
        repeat (3) @(posedge clk);
        INT = 1'b1;
        wait_vld("read2");
        chk("ptch_ff80", {16'd0, ptch_rt}, 32'h0000_FF80);
        wait_wrt("back_to_back", n);
        chk("vld_to_next_wrt", n, 2);
        for (int k = 0; k < 3; k++) begin
            INT = 1'b0;
            repeat (3) @(posedge clk);
            INT = 1'b1;
            repeat (3) @(posedge clk);
        end
        wait_vld("read3");
        chk("ptch_2211", {16'd0, ptch_rt}, 32'h0000_2211);
        wait_vld("read4");
        chk("ptch_4433", {16'd0, ptch_rt}, 32'h0000_4433);
        INT = 1'b0;
        repeat (150) @(posedge clk);
        chk("collapsed_frames_left", exp_frames.size(), 0);

        // Reset in the middle of HI_WAIT
        rd_q.push_back(16'h0055);
        rd_q.push_back(16'h0066);
        exp_frames.push_back(16'hA200);
        exp_frames.push_back(16'hA300);
        @(negedge clk);
        INT = 1'b1;
        wait_wrt("rst_lo", n);
        wait_wrt("rst_hi", n);
        repeat (10) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b0;
        INT   = 1'b0;
        #1;
        chk("async_rst_wrt", {31'd0, spi_wrt}, 32'd0);
        chk("async_rst_cmd", {16'd0, spi_cmd}, 32'd0);
        chk("async_rst_ptch", {16'd0, ptch_rt}, 32'd0);
        chk("async_rst_vld", {31'd0, vld}, 32'd0);
        chk("async_rst_cfg_done", {31'd0, cfg_done}, 32'd0);
        rd_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
        wait_cfg("cfg_done_2");
        repeat (20) @(posedge clk);
        chk("reconfig_frames_left", exp_frames.size(), 0);

        expect_read(16'h0077, 16'h0088);
        @(negedge clk);
        INT = 1'b1;
        wait_vld("read5");
        chk("ptch_8877", {16'd0, ptch_rt}, 32'h0000_8877);
        INT = 1'b0;
        repeat (60) @(posedge clk);
        chk("frames_drained", exp_frames.size(), 0);
        chk("ptch_drained", exp_ptch.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
